// File: rtl/dds_pkg.sv
// dds_pkg -- shared encodings for the interpolating upsampler.
//   modeT      : output mode seen on the Mode port (11 folds to hold)
//   stateT     : control FSM state encoding
//   decodeMode : maps the raw 2-bit Mode port onto modeT
package dds_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_LINEAR = 2'b01,
    MODE_ZSTUFF = 2'b10
  } modeT;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PRIME = 2'b01,
    RUN   = 2'b10
  } stateT;

  function automatic modeT decodeMode(input logic [1:0] modeRaw);
    case (modeRaw)
      2'b01:   return MODE_LINEAR;
      2'b10:   return MODE_ZSTUFF;
      default: return MODE_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/interp_lane.sv
// interp_lane -- one sample lane of the upsampler: PREV/CUR/NXT registers,
// interpolation arithmetic and the registered output word.
// Ports:
//   clk, rstN             clock, synchronous active-low reset
//   loadCur               CUR <= inData
//   shiftIn               PREV <= CUR, CUR <= inData
//   advance               PREV <= CUR, CUR <= NXT
//   flatten               PREV <= CUR (CUR kept, flat segment)
//   loadNxt               NXT <= inData
//   outLoad / outClear    update / clear the output register (clear wins)
//   mode, phase           segment mode and current phase
//   inData / outData      lane sample in / interpolated sample out
import dds_pkg::*;

module interp_lane #(
  parameter int WIDTH      = 16,
  parameter int LOG2_RATIO = 3
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  loadCur,
  input  logic                  shiftIn,
  input  logic                  advance,
  input  logic                  flatten,
  input  logic                  loadNxt,
  input  logic                  outLoad,
  input  logic                  outClear,
  input  modeT                  mode,
  input  logic [LOG2_RATIO-1:0] phase,
  input  logic [WIDTH-1:0]      inData,
  output logic [WIDTH-1:0]      outData
);

  localparam int PW = WIDTH + 1 + LOG2_RATIO;

  logic signed [WIDTH-1:0] prevR, curR, nxtR;
  logic signed [WIDTH:0]   diff;
  logic signed [PW-1:0]    diffExt, phaseExt, prod;
  logic signed [WIDTH:0]   prodShifted;
  logic signed [WIDTH:0]   sum;
  logic        [WIDTH-1:0] linearVal, interpVal;
  logic                    unusedSumTop;

  always_comb begin
    diff     = {curR[WIDTH-1], curR} - {prevR[WIDTH-1], prevR};
    diffExt  = {{LOG2_RATIO{diff[WIDTH]}}, diff};
    phaseExt = {{(WIDTH + 1){1'b0}}, phase};
    prod     = diffExt * phaseExt;
    // Taking the top WIDTH+1 bits is exactly prod >>> LOG2_RATIO (floor).
    prodShifted = prod[PW-1:LOG2_RATIO];
    sum         = {prevR[WIDTH-1], prevR} + prodShifted;
    // The interpolated value always lies between PREV and CUR, so the top
    // bit is a pure sign copy.
    linearVal    = sum[WIDTH-1:0];
    unusedSumTop = sum[WIDTH];
  end

  always_comb begin
    interpVal = prevR;
    case (mode)
      MODE_LINEAR: interpVal = linearVal;
      MODE_ZSTUFF: interpVal = (phase == '0) ? prevR : '0;
      default:     interpVal = prevR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      prevR   <= '0;
      curR    <= '0;
      nxtR    <= '0;
      outData <= '0;
    end else begin
      if (loadCur) curR <= inData;
      if (shiftIn) begin
        prevR <= curR;
        curR  <= inData;
      end
      if (advance) begin
        prevR <= curR;
        curR  <= nxtR;
      end
      if (flatten) prevR <= curR;
      if (loadNxt) nxtR <= inData;
      if (outClear)     outData <= '0;
      else if (outLoad) outData <= interpVal;
    end
  end

endmodule

// File: rtl/interp_upsampler.sv
// interp_upsampler -- multi-lane upsampler by 2^LOG2_RATIO with hold,
// linear and zero-stuff interpolation.
// Ports:
//   Fg_CLK, RESETn   clock, synchronous active-low reset
//   Enable           run enable; low forces IDLE and clears the output
//   Mode             00 hold, 01 linear, 10 zero-stuff, 11 hold
//   InValid/InReady  input handshake, InData lane k at [k*WIDTH +: WIDTH]
//   OutTick          output-rate strobe
//   OutValid/OutData registered output, one cycle after OutTick
//   Underrun         sticky, set when a segment boundary finds no sample
//
// state | meaning
// IDLE  | no samples held; next accept fills CUR
// PRIME | CUR held; next accept fills PREV/CUR and starts output
// RUN   | interpolating PREV->CUR on OutTick; accepts go to NXT
import dds_pkg::*;

module interp_upsampler #(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = 16,
  parameter int LOG2_RATIO = 3
) (
  input  logic                      Fg_CLK,
  input  logic                      RESETn,
  input  logic                      Enable,
  input  logic [1:0]                Mode,
  input  logic                      InValid,
  input  logic [CHANNELS*WIDTH-1:0] InData,
  output logic                      InReady,
  input  logic                      OutTick,
  output logic                      OutValid,
  output logic [CHANNELS*WIDTH-1:0] OutData,
  output logic                      Underrun
);

  stateT                 state, stateNext;
  logic [LOG2_RATIO-1:0] phase;
  logic                  nxtFull;
  modeT                  modeReg, modeEff;
  logic                  outValidR, underrunR;

  logic accept, tickRun, wrap;
  logic laneLoadCur, laneShiftIn, laneAdvance, laneFlatten, laneLoadNxt;
  logic starve;

  // RESETn in the ready term keeps InReady low for the whole reset.
  assign InReady = RESETn & Enable & ~nxtFull;
  assign accept  = InValid & InReady;
  assign tickRun = OutTick & (state == RUN);
  assign wrap    = tickRun & (phase == '1);
  assign modeEff = (phase == '0) ? decodeMode(Mode) : modeReg;

  always_comb begin
    stateNext   = state;
    laneLoadCur = 1'b0;
    laneShiftIn = 1'b0;
    laneAdvance = 1'b0;
    laneFlatten = 1'b0;
    laneLoadNxt = 1'b0;
    starve      = 1'b0;
    if (!Enable) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            laneLoadCur = 1'b1;
            stateNext   = PRIME;
          end
        end
        PRIME: begin
          if (accept) begin
            laneShiftIn = 1'b1;
            stateNext   = RUN;
          end
        end
        RUN: begin
          if (wrap) begin
            // nxtFull blocks accepts, so at most one branch has data.
            if (nxtFull) begin
              laneAdvance = 1'b1;
            end else if (accept) begin
              laneShiftIn = 1'b1;
            end else begin
              laneFlatten = 1'b1;
              starve      = 1'b1;
            end
          end else if (accept) begin
            laneLoadNxt = 1'b1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge Fg_CLK) begin
    if (!RESETn) begin
      state     <= IDLE;
      phase     <= '0;
      nxtFull   <= 1'b0;
      modeReg   <= MODE_HOLD;
      outValidR <= 1'b0;
      underrunR <= 1'b0;
    end else begin
      state <= stateNext;
      if (!Enable) begin
        phase     <= '0;
        nxtFull   <= 1'b0;
        outValidR <= 1'b0;
      end else begin
        outValidR <= tickRun;
        if (laneShiftIn && (state == PRIME)) phase <= '0;
        else if (tickRun)                    phase <= phase + 1'b1;
        if (tickRun && (phase == '0)) modeReg <= modeEff;
        if (laneLoadNxt)      nxtFull <= 1'b1;
        else if (laneAdvance) nxtFull <= 1'b0;
        if (starve) underrunR <= 1'b1;
      end
    end
  end

  assign OutValid = outValidR;
  assign Underrun = underrunR;

  for (genvar k = 0; k < CHANNELS; k++) begin : gLane
    interp_lane #(
      .WIDTH      (WIDTH),
      .LOG2_RATIO (LOG2_RATIO)
    ) uLane (
      .clk      (Fg_CLK),
      .rstN     (RESETn),
      .loadCur  (laneLoadCur),
      .shiftIn  (laneShiftIn),
      .advance  (laneAdvance),
      .flatten  (laneFlatten),
      .loadNxt  (laneLoadNxt),
      .outLoad  (tickRun),
      .outClear (~Enable),
      .mode     (modeEff),
      .phase    (phase),
      .inData   (InData[k*WIDTH +: WIDTH]),
      .outData  (OutData[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_interp_upsampler.sv
// tb_interp_upsampler -- directed bench for interp_upsampler
// (CHANNELS=2, WIDTH=16, LOG2_RATIO=3).
module tb_interp_upsampler;

  logic        Fg_CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        Enable = 1'b0;
  logic [1:0]  Mode = 2'b00;
  logic        InValid = 1'b0;
  logic [31:0] InData = '0;
  logic        InReady;
  logic        OutTick = 1'b0;
  logic        OutValid;
  logic [31:0] OutData;
  logic        Underrun;

  logic signed [15:0] lane0, lane1;
  assign lane0 = OutData[15:0];
  assign lane1 = OutData[31:16];

  int checks = 0;
  int failures = 0;

  always #5 Fg_CLK = ~Fg_CLK;

  interp_upsampler #(
    .CHANNELS   (2),
    .WIDTH      (16),
    .LOG2_RATIO (3)
  ) dut (
    .Fg_CLK   (Fg_CLK),
    .RESETn   (RESETn),
    .Enable   (Enable),
    .Mode     (Mode),
    .InValid  (InValid),
    .InData   (InData),
    .InReady  (InReady),
    .OutTick  (OutTick),
    .OutValid (OutValid),
    .OutData  (OutData),
    .Underrun (Underrun)
  );

  task automatic applyReset();
    RESETn  = 1'b0;
    InValid = 1'b0;
    OutTick = 1'b0;
    repeat (2) @(posedge Fg_CLK);
    #1;
    RESETn = 1'b1;
  endtask

  task automatic pushVec(input int a, input int b);
    InData  = {16'(b), 16'(a)};
    InValid = 1'b1;
    @(posedge Fg_CLK);
    #1;
    InValid = 1'b0;
  endtask

  task automatic doTick();
    OutTick = 1'b1;
    @(posedge Fg_CLK);
    #1;
    OutTick = 1'b0;
  endtask

  task automatic test_reset();
    Enable  = 1'b1;
    Mode    = 2'b01;
    RESETn  = 1'b0;
    InData  = 32'h1234_5678;
    InValid = 1'b1;
    repeat (2) @(posedge Fg_CLK);
    #1;
    checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL rst_inready got %0b want 0", InReady); end
    checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL rst_outvalid got %0b want 0", OutValid); end
    checks++; if (OutData !== 32'd0) begin failures++; $display("FAIL rst_outdata got %0h want 0", OutData); end
    checks++; if (Underrun !== 1'b0) begin failures++; $display("FAIL rst_underrun got %0b want 0", Underrun); end
    InValid = 1'b0;
    RESETn  = 1'b1;
    #1;
    checks++; if (InReady !== 1'b1) begin failures++; $display("FAIL rst_release_inready got %0b want 1", InReady); end
  endtask

  task automatic test_linear();
    applyReset();
    Enable = 1'b1;
    Mode   = 2'b01;
    pushVec(0, 0);
    pushVec(800, -400);
    for (int p = 0; p < 8; p++) begin
      checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL lin_pre_valid p=%0d got %0b want 0", p, OutValid); end
      doTick();
      checks++; if (OutValid !== 1'b1) begin failures++; $display("FAIL lin_valid p=%0d got %0b want 1", p, OutValid); end
      checks++; if (lane0 !== 16'(p * 100)) begin failures++; $display("FAIL lin_lane0 p=%0d got %0d want %0d", p, lane0, p * 100); end
      checks++; if (lane1 !== 16'(-50 * p)) begin failures++; $display("FAIL lin_lane1 p=%0d got %0d want %0d", p, lane1, -50 * p); end
      @(posedge Fg_CLK);
      #1;
      checks++; if (lane0 !== 16'(p * 100)) begin failures++; $display("FAIL lin_hold p=%0d got %0d want %0d", p, lane0, p * 100); end
    end
  endtask

  task automatic test_negative();
    applyReset();
    Enable = 1'b1;
    Mode   = 2'b01;
    pushVec(100, 0);
    pushVec(-100, -8);
    doTick();
    checks++; if (lane0 !== 16'sd100) begin failures++; $display("FAIL neg_p0 got %0d want 100", lane0); end
    doTick();
    checks++; if (lane0 !== 16'sd75) begin failures++; $display("FAIL neg_p1 got %0d want 75", lane0); end
    checks++; if (lane1 !== -16'sd1) begin failures++; $display("FAIL neg_floor got %0d want -1", lane1); end
  endtask

  task automatic test_extremes();
    applyReset();
    Enable = 1'b1;
    Mode   = 2'b01;
    pushVec(-32768, 32767);
    pushVec(32767, -32768);
    repeat (8) doTick();
    checks++; if (lane0 !== 16'sd24575) begin failures++; $display("FAIL ext_up_p7 got %0d want 24575", lane0); end
    checks++; if (lane1 !== -16'sd24577) begin failures++; $display("FAIL ext_dn_p7 got %0d want -24577", lane1); end
  endtask

  task automatic test_hold_zstuff();
    logic [1:0] modes [3];
    int exp;
    modes = '{2'b00, 2'b10, 2'b11};
    for (int m = 0; m < 3; m++) begin
      applyReset();
      Enable = 1'b1;
      Mode   = modes[m];
      pushVec(5, 0);
      pushVec(9, 0);
      for (int p = 0; p < 8; p++) begin
        doTick();
        exp = (modes[m] == 2'b10 && p != 0) ? 0 : 5;
        checks++; if (lane0 !== 16'(exp)) begin failures++; $display("FAIL mode%0d_p%0d got %0d want %0d", modes[m], p, lane0, exp); end
      end
    end
  endtask

  task automatic test_underrun();
    applyReset();
    Enable = 1'b1;
    Mode   = 2'b01;
    pushVec(0, 0);
    pushVec(80, 0);
    for (int p = 0; p < 8; p++) doTick();
    checks++; if (lane0 !== 16'sd70) begin failures++; $display("FAIL ur_seg1_p7 got %0d want 70", lane0); end
    checks++; if (Underrun !== 1'b1) begin failures++; $display("FAIL ur_set got %0b want 1", Underrun); end
    for (int p = 0; p < 3; p++) begin
      doTick();
      checks++; if (lane0 !== 16'sd80) begin failures++; $display("FAIL ur_flat p=%0d got %0d want 80", p, lane0); end
    end
    pushVec(160, 0);
    for (int p = 3; p < 8; p++) begin
      doTick();
      checks++; if (lane0 !== 16'sd80) begin failures++; $display("FAIL ur_flat p=%0d got %0d want 80", p, lane0); end
    end
    doTick();
    checks++; if (lane0 !== 16'sd80) begin failures++; $display("FAIL ur_late_p0 got %0d want 80", lane0); end
    doTick();
    checks++; if (lane0 !== 16'sd90) begin failures++; $display("FAIL ur_late_p1 got %0d want 90", lane0); end
    checks++; if (Underrun !== 1'b1) begin failures++; $display("FAIL ur_sticky got %0b want 1", Underrun); end
    Enable = 1'b0;
    @(posedge Fg_CLK);
    #1;
    checks++; if (Underrun !== 1'b1) begin failures++; $display("FAIL ur_enable_keep got %0b want 1", Underrun); end
    checks++; if (OutData !== 32'd0) begin failures++; $display("FAIL ur_enable_clr got %0h want 0", OutData); end
    Enable = 1'b1;
  endtask

  task automatic test_mode_change_enable();
    applyReset();
    Enable = 1'b1;
    Mode   = 2'b01;
    pushVec(0, 0);
    pushVec(800, 0);
    repeat (3) doTick();
    checks++; if (lane0 !== 16'sd200) begin failures++; $display("FAIL mc_p2 got %0d want 200", lane0); end
    Mode = 2'b00;
    doTick();
    checks++; if (lane0 !== 16'sd300) begin failures++; $display("FAIL mc_p3 got %0d want 300", lane0); end
    pushVec(1600, 0);
    repeat (4) doTick();
    checks++; if (lane0 !== 16'sd700) begin failures++; $display("FAIL mc_p7 got %0d want 700", lane0); end
    doTick();
    checks++; if (lane0 !== 16'sd800) begin failures++; $display("FAIL mc_hold_p0 got %0d want 800", lane0); end
    doTick();
    checks++; if (lane0 !== 16'sd800) begin failures++; $display("FAIL mc_hold_p1 got %0d want 800", lane0); end
    pushVec(2400, 0);
    checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL en_full_inready got %0b want 0", InReady); end
    Enable = 1'b0;
    @(posedge Fg_CLK);
    #1;
    checks++; if (OutData !== 32'd0) begin failures++; $display("FAIL en_outdata got %0h want 0", OutData); end
    checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL en_outvalid got %0b want 0", OutValid); end
    Enable = 1'b1;
    #1;
    checks++; if (InReady !== 1'b1) begin failures++; $display("FAIL en_inready got %0b want 1", InReady); end
    doTick();
    checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL en_idle_tick got %0b want 0", OutValid); end
    checks++; if (Underrun !== 1'b0) begin failures++; $display("FAIL mc_underrun got %0b want 0", Underrun); end
  endtask

  task automatic test_back_to_back();
    applyReset();
    Enable  = 1'b1;
    Mode    = 2'b01;
    InValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      InData = {16'd0, 16'(i * 800)};
      @(posedge Fg_CLK);
      #1;
    end
    checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL b2b_full got %0b want 0", InReady); end
    @(posedge Fg_CLK);
    #1;
    checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL b2b_full_hold got %0b want 0", InReady); end
    InValid = 1'b0;
    for (int p = 0; p < 8; p++) begin
      doTick();
      checks++; if (lane0 !== 16'(p * 100)) begin failures++; $display("FAIL b2b_seg1 p=%0d got %0d want %0d", p, lane0, p * 100); end
    end
    checks++; if (InReady !== 1'b1) begin failures++; $display("FAIL b2b_drain got %0b want 1", InReady); end
    doTick();
    checks++; if (lane0 !== 16'sd800) begin failures++; $display("FAIL b2b_seg2_p0 got %0d want 800", lane0); end
    doTick();
    checks++; if (lane0 !== 16'sd900) begin failures++; $display("FAIL b2b_seg2_p1 got %0d want 900", lane0); end
    repeat (5) doTick();
    InData  = {16'd0, 16'd3200};
    InValid = 1'b1;
    OutTick = 1'b1;
    @(posedge Fg_CLK);
    #1;
    InValid = 1'b0;
    OutTick = 1'b0;
    checks++; if (lane0 !== 16'sd1500) begin failures++; $display("FAIL b2b_seg2_p7 got %0d want 1500", lane0); end
    checks++; if (Underrun !== 1'b0) begin failures++; $display("FAIL b2b_bypass_underrun got %0b want 0", Underrun); end
    checks++; if (InReady !== 1'b1) begin failures++; $display("FAIL b2b_bypass_ready got %0b want 1", InReady); end
    doTick();
    checks++; if (lane0 !== 16'sd1600) begin failures++; $display("FAIL b2b_seg3_p0 got %0d want 1600", lane0); end
    doTick();
    checks++; if (lane0 !== 16'sd1800) begin failures++; $display("FAIL b2b_seg3_p1 got %0d want 1800", lane0); end
    pushVec(4000, 0);
    RESETn = 1'b0;
    @(posedge Fg_CLK);
    #1;
    checks++; if (OutData !== 32'd0) begin failures++; $display("FAIL midrst_outdata got %0h want 0", OutData); end
    checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL midrst_outvalid got %0b want 0", OutValid); end
    checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL midrst_inready got %0b want 0", InReady); end
    RESETn = 1'b1;
    #1;
    checks++; if (InReady !== 1'b1) begin failures++; $display("FAIL midrst_release got %0b want 1", InReady); end
    doTick();
    checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL midrst_tick got %0b want 0", OutValid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_linear();
    test_negative();
    test_extremes();
    test_hold_zstuff();
    test_underrun();
    test_mode_change_enable();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
